// File: rtl/lot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lot_pkg
// Description : Shared FSM state encoding and default parameters for the
//               parking-lot barrier controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lot_pkg;

    localparam int DEF_CAPACITY     = 16;
    localparam int DEF_OPEN_TIMEOUT = 1000;
    localparam int DEF_CLOSE_CYCLES = 4;

    // Barrier controller states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN_IN  = 2'd1,
        ST_OPEN_OUT = 2'd2,
        ST_CLOSING  = 2'd3
    } lot_state_e;

endpackage : lot_pkg
`default_nettype wire

// File: rtl/lot_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lot_access_ctrl_if
// Description : Request / detector / barrier-status bundle of the lot
//               controller. The controller uses the slave view, the
//               environment driving requests and detector pulses the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface lot_access_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             entry_req;
    logic             exit_req;
    logic             car_in;
    logic             car_out;
    logic             gate_open;
    logic             grant_entry;
    logic             grant_exit;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             timeout_err;
    logic             count_err;

    modport slave (
        input  entry_req, exit_req, car_in, car_out,
        output gate_open, grant_entry, grant_exit, count, full, empty,
               timeout_err, count_err
    );

    modport master (
        output entry_req, exit_req, car_in, car_out,
        input  gate_open, grant_entry, grant_exit, count, full, empty,
               timeout_err, count_err
    );

endinterface : lot_access_ctrl_if
`default_nettype wire

// File: rtl/occ_counter.sv
`default_nettype none
// ============================================================================
// Module      : occ_counter
// Description : Saturating up/down occupancy counter. Simultaneous up and
//               down cancel; an update past either bound holds the count and
//               raises a one-cycle error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module occ_counter #(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             dec,
    output logic      [CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  count_err
);

    localparam logic [CNT_W-1:0] c_cap = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] count_d, count_q;
    logic             err_d, err_q;

    // Next count: cancel on both, saturate and flag at either bound
    always_comb begin
        count_d = count_q;
        err_d   = 1'b0;
        if (inc && !dec) begin
            if (count_q == c_cap) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Count and error pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count     = count_q;
    assign full      = (count_q == c_cap);
    assign empty     = (count_q == '0);
    assign count_err = err_q;

endmodule : occ_counter
`default_nettype wire

// File: rtl/lot_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lot_access_ctrl
// Description : Single-barrier parking-lot access controller. Arbitrates
//               entry/exit requests round-robin, holds the barrier open until
//               the matching passage or a timeout, enforces a closing guard
//               time and tracks occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module lot_access_ctrl
    import lot_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int CNT_W        = $clog2(CAPACITY + 1)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    lot_access_ctrl_if.slave  bus
);

    // One timer serves both the open timeout and the closing guard time
    localparam int c_tmr_max = (OPEN_TIMEOUT > CLOSE_CYCLES) ? OPEN_TIMEOUT : CLOSE_CYCLES;
    localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;
    localparam logic [c_tmr_w-1:0] c_open_last  = c_tmr_w'(OPEN_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_close_last = c_tmr_w'(CLOSE_CYCLES - 1);

    lot_state_e         state_d, state_q;
    logic [c_tmr_w-1:0] tmr_d, tmr_q;
    logic               favour_exit_d, favour_exit_q;
    logic               timeout_d, timeout_q;

    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_count_err;
    logic               w_entry_ok;
    logic               w_pick_exit;

    occ_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occ_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (bus.car_in),
        .dec       (bus.car_out),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty),
        .count_err (w_count_err)
    );

    // Arbitration: an entry needs space; on contention take the side not served last
    always_comb begin
        w_entry_ok  = bus.entry_req && !w_full;
        w_pick_exit = bus.exit_req && (!w_entry_ok || favour_exit_q);
    end

    // Next-state, timer and round-robin update
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q + c_tmr_w'(1);
        favour_exit_d = favour_exit_q;
        timeout_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (w_pick_exit) begin
                    state_d       = ST_OPEN_OUT;
                    favour_exit_d = 1'b0;
                end else if (w_entry_ok) begin
                    state_d       = ST_OPEN_IN;
                    favour_exit_d = 1'b1;
                end
            end
            ST_OPEN_IN: begin
                if (bus.car_in) begin
                    state_d = ST_CLOSING;
                    tmr_d   = '0;
                end else if (tmr_q == c_open_last) begin
                    state_d   = ST_CLOSING;
                    tmr_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_OPEN_OUT: begin
                if (bus.car_out) begin
                    state_d = ST_CLOSING;
                    tmr_d   = '0;
                end else if (tmr_q == c_open_last) begin
                    state_d   = ST_CLOSING;
                    tmr_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_CLOSING: begin
                if (tmr_q == c_close_last) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Controller state registers; reset favours exit on first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            favour_exit_q <= 1'b1;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            favour_exit_q <= favour_exit_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.gate_open   = (state_q == ST_OPEN_IN) || (state_q == ST_OPEN_OUT);
    assign bus.grant_entry = (state_q == ST_OPEN_IN);
    assign bus.grant_exit  = (state_q == ST_OPEN_OUT);
    assign bus.timeout_err = timeout_q;
    assign bus.count       = w_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.count_err   = w_count_err;

endmodule : lot_access_ctrl
`default_nettype wire

// File: tb/tb_lot_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lot_access_ctrl
// Description : Self-checking bench for lot_access_ctrl: directed scenarios
//               followed by random traffic, all compared every cycle against
//               an event/deadline based reference model of the lot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lot_access_ctrl;

    localparam int CAP = 4;
    localparam int OT  = 8;
    localparam int CC  = 2;
    localparam int CW  = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lot_access_ctrl_if #(.CNT_W(CW)) bus ();

    lot_access_ctrl #(
        .CAPACITY     (CAP),
        .OPEN_TIMEOUT (OT),
        .CLOSE_CYCLES (CC),
        .CNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase of the barrier plus absolute edge deadlines
    int m_phase;      // 0 idle, 1 open for entry, 2 open for exit, 3 closing
    int m_count;
    bit m_prefer_exit;
    int m_deadline;   // edge at which an unused opening is forced shut
    int m_reopen;     // edge at which the closing guard time ends
    bit m_terr;
    bit m_cerr;
    int edge_n;

    task automatic model_edge(input bit r, input bit er, input bit xr, input bit ci, input bit co);
        bit was_full;
        bit want_in;
        bit take_exit;
        edge_n++;
        if (r) begin
            m_phase = 0; m_count = 0; m_prefer_exit = 1'b1;
            m_terr = 1'b0; m_cerr = 1'b0;
            return;
        end
        was_full = (m_count == CAP);
        m_terr = 1'b0;
        m_cerr = 1'b0;
        if (ci && !co) begin
            if (m_count == CAP) m_cerr = 1'b1; else m_count++;
        end else if (co && !ci) begin
            if (m_count == 0) m_cerr = 1'b1; else m_count--;
        end
        case (m_phase)
            0: begin
                want_in   = er && !was_full;
                take_exit = xr && (!want_in || m_prefer_exit);
                if (want_in || xr) begin
                    m_phase       = take_exit ? 2 : 1;
                    m_prefer_exit = !take_exit;
                    m_deadline    = edge_n + OT;
                end
            end
            1, 2: begin
                if ((m_phase == 1 && ci) || (m_phase == 2 && co)) begin
                    m_phase = 3; m_reopen = edge_n + CC;
                end else if (edge_n == m_deadline) begin
                    m_phase = 3; m_reopen = edge_n + CC; m_terr = 1'b1;
                end
            end
            default: begin
                if (edge_n == m_reopen) m_phase = 0;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("gate_open",   32'(bus.gate_open),   32'(m_phase == 1 || m_phase == 2));
        check("grant_entry", 32'(bus.grant_entry), 32'(m_phase == 1));
        check("grant_exit",  32'(bus.grant_exit),  32'(m_phase == 2));
        check("count",       32'(bus.count),       32'(m_count));
        check("full",        32'(bus.full),        32'(m_count == CAP));
        check("empty",       32'(bus.empty),       32'(m_count == 0));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        check("count_err",   32'(bus.count_err),   32'(m_cerr));
    endtask

    // One clock: model follows the sampled inputs, outputs checked 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge(rst, bus.entry_req, bus.exit_req, bus.car_in, bus.car_out);
        #1;
        check_model();
    endtask

    task automatic do_entry();
        bus.entry_req = 1'b1; step();
        bus.entry_req = 1'b0; step();
        bus.car_in    = 1'b1; step();
        bus.car_in    = 1'b0;
        repeat (CC + 1) step();
    endtask

    task automatic do_exit();
        bus.exit_req = 1'b1; step();
        bus.exit_req = 1'b0; step();
        bus.car_out  = 1'b1; step();
        bus.car_out  = 1'b0;
        repeat (CC + 1) step();
    endtask

    initial begin
        total = 0; bad = 0; edge_n = 0;
        m_phase = 0; m_count = 0; m_prefer_exit = 1'b1; m_terr = 1'b0; m_cerr = 1'b0;
        m_deadline = 0; m_reopen = 0;
        rst = 1'b1;
        bus.entry_req = 1'b0; bus.exit_req = 1'b0;
        bus.car_in    = 1'b0; bus.car_out  = 1'b0;

        // Reset state
        step(); step();
        check("rst_gate",  32'(bus.gate_open), 32'd0);
        check("rst_empty", 32'(bus.empty),     32'd1);
        check("rst_full",  32'(bus.full),      32'd0);
        rst = 1'b0;
        step();

        // Single entry: open cycles 1-3, passage in cycle 3, count 1
        bus.entry_req = 1'b1; step();
        bus.entry_req = 1'b0;
        check("single_c1", 32'(bus.gate_open), 32'd1);
        step();
        check("single_c2", 32'(bus.gate_open), 32'd1);
        step();
        check("single_c3", 32'(bus.gate_open), 32'd1);
        bus.car_in = 1'b1; step();
        bus.car_in = 1'b0;
        check("single_c4", 32'(bus.gate_open), 32'd0);
        repeat (CC) step();
        check("single_cnt", 32'(bus.count), 32'd1);

        // Contention from reset: exit, entry, exit
        rst = 1'b1; step();
        rst = 1'b0;
        bus.entry_req = 1'b1; bus.exit_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 20 && !bus.gate_open; w++) step();
            check("rr_open", 32'(bus.gate_open), 32'd1);
            check("rr_dir",  32'(bus.grant_exit), (k == 1) ? 32'd0 : 32'd1);
            if (bus.grant_exit) bus.car_out = 1'b1; else bus.car_in = 1'b1;
            step();
            bus.car_out = 1'b0; bus.car_in = 1'b0;
        end
        bus.entry_req = 1'b0; bus.exit_req = 1'b0;
        repeat (CC + 1) step();

        // Full lot: four entries, fifth refused, stray car_in flagged
        rst = 1'b1; step();
        rst = 1'b0; step();
        repeat (4) do_entry();
        check("full_cnt",  32'(bus.count), 32'd4);
        check("full_flag", 32'(bus.full),  32'd1);
        bus.entry_req = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            check("full_nogrant", 32'(bus.grant_entry), 32'd0);
        end
        bus.car_in = 1'b1; step();
        bus.car_in = 1'b0;
        check("full_cerr", 32'(bus.count_err), 32'd1);
        check("full_hold", 32'(bus.count),     32'd4);
        bus.entry_req = 1'b0; step();

        // Timeout: exit granted, no car_out, pulse exactly OT cycles after the open
        bus.exit_req = 1'b1; step();
        bus.exit_req = 1'b0;
        check("to_open", 32'(bus.grant_exit), 32'd1);
        repeat (OT - 1) step();
        check("to_early", 32'(bus.timeout_err), 32'd0);
        step();
        check("to_pulse", 32'(bus.timeout_err), 32'd1);
        check("to_gate",  32'(bus.gate_open),   32'd0);
        check("to_cnt",   32'(bus.count),       32'd4);
        repeat (CC + 1) step();

        // Simultaneous pulses at count 2
        do_exit(); do_exit();
        bus.car_in = 1'b1; bus.car_out = 1'b1; step();
        bus.car_in = 1'b0; bus.car_out = 1'b0;
        check("sim_cnt",  32'(bus.count),     32'd2);
        check("sim_cerr", 32'(bus.count_err), 32'd0);

        // Passage in the same cycle as the timeout wins
        bus.entry_req = 1'b1; step();
        bus.entry_req = 1'b0;
        repeat (OT - 1) step();
        bus.car_in = 1'b1; step();
        bus.car_in = 1'b0;
        check("race_terr", 32'(bus.timeout_err), 32'd0);
        check("race_cnt",  32'(bus.count),       32'd3);
        repeat (CC + 1) step();

        // Reset while open for entry at count 3
        bus.entry_req = 1'b1; step();
        bus.entry_req = 1'b0;
        check("mid_open", 32'(bus.grant_entry), 32'd1);
        rst = 1'b1; step();
        rst = 1'b0;
        check("mid_gate",  32'(bus.gate_open), 32'd0);
        check("mid_cnt",   32'(bus.count),     32'd0);
        check("mid_empty", 32'(bus.empty),     32'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.entry_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.exit_req  = 1'($urandom_range(0, 1));
            bus.car_in  = ($urandom_range(0, 5) == 0);
            bus.car_out = ($urandom_range(0, 6) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lot_access_ctrl
`default_nettype wire

// File: doc/lot_access_ctrl.md
LOT_ACCESS_CTRL -- requirements
Module: lot_access_ctrl

Interface
REQ-001 The module SHALL have parameter CAPACITY, default 16, meaning the maximum number of vehicles in the lot.
REQ-002 The module SHALL have parameter OPEN_TIMEOUT, default 1000, meaning the cycles a barrier stays open without a passage before forced close.
REQ-003 The module SHALL have parameter CLOSE_CYCLES, default 4, meaning the barrier closing guard time in cycles.
REQ-004 The module SHALL have parameter CNT_W, default $clog2(CAPACITY+1), meaning the occupancy width.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port entry_req, input, 1 bit: level request to open the barrier for entry.
REQ-008 The module SHALL have port exit_req, input, 1 bit: level request to open the barrier for exit.
REQ-009 The module SHALL have port car_in, input, 1 bit: one-cycle pulse from the direction detector E meaning a vehicle entered.
REQ-010 The module SHALL have port car_out, input, 1 bit: one-cycle pulse from the direction detector S meaning a vehicle left.
REQ-011 The module SHALL have port gate_open, output, 1 bit: barrier open command.
REQ-012 The module SHALL have ports grant_entry and grant_exit, output, 1 bit each: the current barrier owner.
REQ-013 The module SHALL have port count, output, CNT_W bits: current occupancy.
REQ-014 The module SHALL have ports full and empty, output, 1 bit each: full is count==CAPACITY; empty is count==0.
REQ-015 The module SHALL have port timeout_err, output, 1 bit: one-cycle pulse on forced close.
REQ-016 The module SHALL have port count_err, output, 1 bit: one-cycle pulse on an illegal count update.

Function
REQ-017 FSM states SHALL be IDLE, OPEN_IN, OPEN_OUT and CLOSING; all outputs SHALL be registered or decoded from registered state only.
REQ-018 In IDLE, at edge k, entry_req with !full SHALL move the FSM to OPEN_IN; exit_req SHALL move it to OPEN_OUT. gate_open and the matching grant SHALL be high from cycle k+1.
REQ-019 entry_req while full SHALL be ignored (no grant) in IDLE.
REQ-020 If both requests are eligible in IDLE, a round-robin bit SHALL choose the direction not granted last; after reset the bit SHALL favour exit.
REQ-021 OPEN_IN SHALL go to CLOSING on car_in; OPEN_OUT SHALL go to CLOSING on car_out. A pulse of the opposite direction SHALL not close the barrier.
REQ-022 The open-timer SHALL clear on entry to OPEN_*. When it reaches OPEN_TIMEOUT-1 without a passage, the FSM SHALL go to CLOSING and pulse timeout_err for one cycle.
REQ-023 If a passage and timeout occur in the same cycle, the passage SHALL win and timeout_err SHALL stay low.
REQ-024 CLOSING SHALL last exactly CLOSE_CYCLES cycles with gate_open and both grants low, then return to IDLE. Requests during CLOSING SHALL be held off, not lost, because they are levels.
REQ-025 Occupancy SHALL update independently of FSM state: car_in increments count and car_out decrements it.
REQ-026 car_in and car_out in the same cycle SHALL leave count unchanged, with no error.
REQ-027 car_in alone at count==CAPACITY SHALL hold count and pulse count_err. car_out alone at count==0 SHALL hold count and pulse count_err. count SHALL never wrap.
REQ-028 full and empty SHALL reflect the registered count in the same cycle as count.

Reset
REQ-029 While rst is high at a clock edge, the FSM SHALL go to IDLE, count to 0, the timers to 0 and the round-robin bit to favour exit.
REQ-030 While rst is high at a clock edge, outputs SHALL be gate_open=0, grant_entry=0, grant_exit=0, full=0, empty=1, timeout_err=0 and count_err=0.
REQ-031 Reset asserted mid-operation, including in OPEN_* or CLOSING, SHALL take effect at the next edge and override all pulses.

Structure
REQ-032 The state encodings and the default CAPACITY, OPEN_TIMEOUT and CLOSE_CYCLES SHALL live in shared package lot_pkg.
REQ-033 The saturating up/down occupancy counter, with its count, full, empty and count_err logic, SHALL be sub-module occ_counter, instantiated once.

Verification (CAPACITY=4, OPEN_TIMEOUT=8, CLOSE_CYCLES=2)
REQ-034 Single entry: entry_req at edge 0, car_in at cycle 3 -> gate_open high in cycles 1-3, CLOSING for 2 cycles, IDLE, count=1.
REQ-035 Contention: entry_req and exit_req held together from reset -> grants alternate exit, entry, exit across successive openings.
REQ-036 Full lot: four entries -> count=4, full=1; a fifth entry_req is never granted; a stray car_in pulses count_err and count stays 4.
REQ-037 Timeout: exit_req granted with no car_out -> timeout_err pulse exactly 8 cycles after the open, then CLOSING, count unchanged.
REQ-038 Simultaneous pulses: car_in and car_out in the same cycle at count=2 -> count=2, count_err=0.
REQ-039 Reset mid-open: rst in OPEN_IN at count=3 -> next cycle IDLE, gate_open=0, count=0, empty=1.
